// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the serial adder/subtractor: controller state
// encoding and the meaning of the Ci mode input.
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
// Purely combinational CHUNK-bit adder slice with carry in/out. Subtraction is
// done by the caller (inverted B, carry-in of 1). Also usable on its own as a
// full-width combinational adder when CHUNK equals the operand width.
//
// Ports:
//   a, b  in  CHUNK  addends
//   cin   in  1      carry into bit 0
//   s     out CHUNK  sum
//   cout  out 1      carry out of the MSB
//   cmsb  out 1      carry into the MSB (for signed-overflow detection)
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s      = w_full[CHUNK-1:0];
  assign cout   = w_full[CHUNK];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
  // of the sum without a separate ripple chain.
  assign cmsb   = w_full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
// Multi-cycle WIDTH-bit adder/subtractor that pushes CHUNK bits per clock
// (LSB chunk first) through one shared addsub_chunk slice. Valid/ready
// handshake on both sides; one operation in flight at a time.
//
// Ports:
//   clk        in  1      clock, all state on the rising edge
//   rst_n      in  1      synchronous active-low reset
//   in_valid   in  1      operand set A, B, Ci valid
//   in_ready   out 1      block can accept an operand set (IDLE)
//   A, B       in  WIDTH  operands
//   Ci         in  1      0 = A+B, 1 = A-B
//   out_valid  out 1      S, Co, V hold a completed result (DONE)
//   out_ready  in  1      consumer accepts the result
//   S          out WIDTH  result
//   Co         out 1      carry out of MSB (subtract: 1 = no borrow)
//   V          out 1      signed overflow
// WIDTH must be an integer multiple of CHUNK.
// -----------------------------------------------------------------------------
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             V
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // B already conditioned for the mode
  logic [WIDTH-1:0]   r_acc;    // working result, filled chunk by chunk
  logic [WIDTH-1:0]   r_s;      // published result, only updated on completion
  logic               r_carry;
  logic               r_co;
  logic               r_v;
  logic [CNT_W-1:0]   r_cnt;

  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK-1:0]   w_sum;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_acc_next;

  // ---------------------------------------------------------------------------
  // Shared arithmetic slice
  // ---------------------------------------------------------------------------
  assign w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_last    = (r_cnt == CNT_W'(N - 1));

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout),
    .cmsb (w_cmsb)
  );

  // Working result with the current chunk merged in; on the last chunk this
  // is the complete result and is published straight to r_s.
  always_comb begin
    w_acc_next                        = r_acc;
    w_acc_next[r_cnt*CHUNK +: CHUNK]  = w_sum;
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ST_CALC;
      end
      ST_CALC: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_v     <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= (Ci == MODE_SUB) ? ~B : B;
      r_carry <= Ci;
      r_cnt   <= '0;
    end else if (r_state == ST_CALC) begin
      r_acc   <= w_acc_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s  <= w_acc_next;
        r_co <= w_cout;
        r_v  <= w_cmsb ^ w_cout;
      end
    end
  end

  assign S  = r_s;
  assign Co = r_co;
  assign V  = r_v;

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
// Self-checking bench for addsub_serial. Three instances share the clock:
//   idx 0: WIDTH=16 CHUNK=4  (N=4)
//   idx 1: WIDTH=16 CHUNK=16 (N=1)
//   idx 2: WIDTH=16 CHUNK=1  (N=16)
// Expected results come from directed constants and from a signed/unsigned
// integer reference model.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        v;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    res_t        exp;
  } vec_t;

  localparam int NI = 3;
  localparam int N_OF [NI] = '{4, 1, 16};

  logic        clk = 1'b0;
  logic        rst_n    [NI];
  logic        iv       [NI];
  logic        ir       [NI];
  logic [15:0] a        [NI];
  logic [15:0] b        [NI];
  logic        ci       [NI];
  logic        ov       [NI];
  logic        ordy     [NI];
  logic [15:0] s        [NI];
  logic        co       [NI];
  logic        vv       [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a[0]), .B(b[0]), .Ci(ci[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .S(s[0]), .Co(co[0]), .V(vv[0])
  );

  addsub_serial #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a[1]), .B(b[1]), .Ci(ci[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .S(s[1]), .Co(co[1]), .V(vv[1])
  );

  addsub_serial #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a[2]), .B(b[2]), .Ci(ci[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .S(s[2]), .Co(co[2]), .V(vv[2])
  );

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the operand values.
  // ---------------------------------------------------------------------------
  function automatic res_t model(input logic [15:0] a_in, input logic [15:0] b_in,
                                 input logic ci_in);
    res_t r;
    int   ua = int'(a_in);
    int   ub = int'(b_in);
    int   sa = int'($signed(a_in));
    int   sb = int'($signed(b_in));
    int   sr;
    int   ur;
    if (ci_in) begin
      sr   = sa - sb;
      ur   = ua - ub;
      r.co = (ua >= ub);
    end else begin
      sr   = sa + sb;
      ur   = ua + ub;
      r.co = (ur > 65535);
    end
    r.s = ur[15:0];
    r.v = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] a_in, input logic [15:0] b_in,
                              input logic ci_in, input logic [15:0] s_exp,
                              input logic co_exp, input logic v_exp);
    vec_t t;
    t.a      = a_in;
    t.b      = b_in;
    t.ci     = ci_in;
    t.exp.s  = s_exp;
    t.exp.co = co_exp;
    t.exp.v  = v_exp;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation: accept, wait for the result, optionally stall the
  // consumer, then handshake. Checks result, latency, hold and release.
  task automatic run_op(input int idx, input logic [15:0] a_in, input logic [15:0] b_in,
                        input logic ci_in, input int stall, input res_t exp,
                        input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(ir[idx]), 32'd1);
    iv[idx]   = 1'b1;
    a[idx]    = a_in;
    b[idx]    = b_in;
    ci[idx]   = ci_in;
    ordy[idx] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    iv[idx] = 1'b0;
    a[idx]  = 16'($urandom);
    b[idx]  = 16'($urandom);
    ci[idx] = 1'($urandom);
    check({tag, "_in_ready_busy"}, 32'(ir[idx]), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ov[idx] && lat < 64);
    if (!ov[idx]) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N_OF[idx]));
    for (int i = 0; i < stall; i++) begin
      check({tag, "_stall_valid"}, 32'(ov[idx]), 32'd1);
      check({tag, "_stall_S"}, 32'(s[idx]), 32'(exp.s));
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_S"},  32'(s[idx]),  32'(exp.s));
    check({tag, "_Co"}, 32'(co[idx]), 32'(exp.co));
    check({tag, "_V"},  32'(vv[idx]), 32'(exp.v));
    ordy[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(ov[idx]), 32'd0);
    check({tag, "_ready_back"}, 32'(ir[idx]), 32'd1);
    check({tag, "_S_held"}, 32'(s[idx]), 32'(exp.s));
  endtask

  // Two operand sets with in_valid held high; the second must be taken in
  // the IDLE cycle right after the first handshake.
  task automatic back_to_back(input int idx);
    int   t0 = -1;
    int   t1 = -1;
    int   seen = 0;
    bit   acc1 = 1'b0;
    logic last_ov = 1'b0;
    string tag = $sformatf("b2b_n%0d", N_OF[idx]);
    @(negedge clk);
    ordy[idx] = 1'b1;
    iv[idx]   = 1'b1;
    a[idx]    = 16'h0006;
    b[idx]    = 16'h0009;
    ci[idx]   = 1'b0;
    for (int c = 0; c < 200 && seen < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (!acc1 && !ir[idx]) begin
        acc1   = 1'b1;
        a[idx] = 16'h7FFF;
        b[idx] = 16'h0001;
      end
      if (ov[idx] && !last_ov) begin
        if (seen == 0) begin
          t0 = c;
          check({tag, "_S1"}, 32'(s[idx]), 32'h000F);
        end else begin
          t1 = c;
          check({tag, "_S2"}, 32'(s[idx]), 32'h8000);
          check({tag, "_V2"}, 32'(vv[idx]), 32'd1);
          iv[idx] = 1'b0;
        end
        seen++;
      end
      last_ov = ov[idx];
    end
    iv[idx] = 1'b0;
    check({tag, "_pulses"}, 32'(seen), 32'd2);
    check({tag, "_spacing"}, 32'(t1 - t0), 32'(N_OF[idx] + 2));
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[7];

  initial begin
    res_t exp_r;

    vecs[0] = mk(16'h0006, 16'h0009, 1'b0, 16'h000F, 1'b0, 1'b0);
    vecs[1] = mk(16'h0006, 16'h0009, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    vecs[2] = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    vecs[3] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    vecs[4] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    vecs[5] = mk(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    vecs[6] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      iv[i]    = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
      ci[i]    = 1'b0;
      ordy[i]  = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_in_ready_%0d", i),  32'(ir[i]), 32'd1);
      check($sformatf("reset_out_valid_%0d", i), 32'(ov[i]), 32'd0);
      check($sformatf("reset_S_%0d", i),  32'(s[i]),  32'd0);
      check($sformatf("reset_Co_%0d", i), 32'(co[i]), 32'd0);
      check($sformatf("reset_V_%0d", i),  32'(vv[i]), 32'd0);
      rst_n[i] = 1'b1;
    end

    // Directed vectors on every chunk width.
    for (int i = 0; i < NI; i++) begin
      for (int v = 0; v < 7; v++) begin
        run_op(i, vecs[v].a, vecs[v].b, vecs[v].ci, 0, vecs[v].exp,
               $sformatf("vec%0d_n%0d", v, N_OF[i]));
      end
    end

    // Consumer backpressure: result held, input pulses ignored.
    begin
      int lat = 0;
      exp_r = model(16'h1357, 16'h2468, 1'b0);
      @(negedge clk);
      iv[0] = 1'b1; a[0] = 16'h1357; b[0] = 16'h2468; ci[0] = 1'b0; ordy[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      while (!ov[0] && lat < 64) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      check("bp_valid_seen", 32'(ov[0]), 32'd1);
      for (int i = 0; i < 10; i++) begin
        check("bp_valid", 32'(ov[0]), 32'd1);
        check("bp_in_ready", 32'(ir[0]), 32'd0);
        check("bp_S", 32'(s[0]), 32'(exp_r.s));
        check("bp_Co", 32'(co[0]), 32'(exp_r.co));
        check("bp_V", 32'(vv[0]), 32'(exp_r.v));
        iv[0] = i[0];
        a[0]  = 16'($urandom);
        b[0]  = 16'($urandom);
        ci[0] = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_valid", 32'(ov[0]), 32'd0);
      check("bp_release_ready", 32'(ir[0]), 32'd1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("bp_no_phantom_op", 32'(ov[0]), 32'd0);
      check("bp_S_kept", 32'(s[0]), 32'(exp_r.s));
    end

    // Reset in the middle of CALC; first leave a nonzero result behind.
    run_op(0, 16'h8000, 16'h0001, 1'b1, 0, model(16'h8000, 16'h0001, 1'b1), "pre_rst");
    @(negedge clk);
    iv[0] = 1'b1; a[0] = 16'hAAAA; b[0] = 16'h5555; ci[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b1;
    check("rst_calc_in_ready", 32'(ir[0]), 32'd1);
    check("rst_calc_out_valid", 32'(ov[0]), 32'd0);
    check("rst_calc_S", 32'(s[0]), 32'd0);
    check("rst_calc_Co", 32'(co[0]), 32'd0);
    check("rst_calc_V", 32'(vv[0]), 32'd0);
    run_op(0, 16'h1234, 16'h1111, 1'b0, 0, model(16'h1234, 16'h1111, 1'b0), "post_rst");

    // Back-to-back throughput on every chunk width.
    for (int i = 0; i < NI; i++) back_to_back(i);

    // Randomized operations with random consumer stalls.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 20; k++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        run_op(i, ra, rb, rc, int'($urandom_range(0, 3)), model(ra, rb, rc),
               $sformatf("rnd%0d_n%0d", k, N_OF[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
